// File: rtl/game_end_ctrl.sv
// Game-over sequencer: latches the end cause, drives the end-screen overlay, freezes play and issues a restart pulse.
// Latency: all outputs registered, changing one clk edge after their cause; no flow control (pulse/level inputs only).
// Build option: GAME_END_AUTO_RESTART_EN adds an auto-restart once the end screen has been shown for HOLD_FRAMES frames.
module game_end_ctrl #(
   parameter int MIN_HOLD_FRAMES = 30,
   parameter int HOLD_FRAMES     = 300,
   parameter int FRAME_CNT_W     = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic game_running,
   input  logic time_up,
   input  logic jump_fail_evt,
   input  logic frame_tick,
   input  logic btn_press,
   output logic end_en,
   output logic jump_fail,
   output logic freeze,
   output logic restart
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_HOLD,
      S_WAIT,
      S_RST_P
   } state_t;

   localparam logic [FRAME_CNT_W-1:0] MIN_CNT = FRAME_CNT_W'(MIN_HOLD_FRAMES);
   localparam logic [FRAME_CNT_W-1:0] CNT_MAX = '1;

   state_t                 state, state_nxt;
   logic [FRAME_CNT_W-1:0] frame_cnt, frame_cnt_nxt;
   logic                   jump_fail_nxt;
   logic                   end_en_nxt;
   logic                   restart_nxt;
   logic                   cnt_inc;
   logic                   timeout;

`ifdef GAME_END_AUTO_RESTART_EN
   localparam logic [FRAME_CNT_W-1:0] HOLD_CNT = FRAME_CNT_W'(HOLD_FRAMES);
   assign timeout = (frame_cnt == HOLD_CNT);
`else
   assign timeout = 1'b0;
`endif

   // Saturating frame counter; never wraps back into the button-lockout window.
   assign cnt_inc = frame_tick && (frame_cnt != CNT_MAX);

   always_comb begin
      state_nxt     = state;
      frame_cnt_nxt = frame_cnt;
      jump_fail_nxt = jump_fail;
      case (state)
         S_IDLE: begin
            if (game_running) state_nxt = S_ARMED;
         end
         S_ARMED: begin
            // A missed jump outranks a simultaneous timer expiry.
            if (jump_fail_evt || time_up) begin
               state_nxt     = S_HOLD;
               jump_fail_nxt = jump_fail_evt;
               frame_cnt_nxt = '0;
            end else if (!game_running) begin
               state_nxt = S_IDLE;
            end
         end
         S_HOLD: begin
            if (cnt_inc) frame_cnt_nxt = frame_cnt + 1'b1;
            if (frame_cnt == MIN_CNT) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_inc) frame_cnt_nxt = frame_cnt + 1'b1;
            if (btn_press || timeout) state_nxt = S_RST_P;
         end
         S_RST_P: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Overlay stays up through the restart cycle and drops on the return to IDLE.
   assign end_en_nxt  = (state_nxt == S_HOLD) || (state_nxt == S_WAIT) || (state_nxt == S_RST_P);
   assign restart_nxt = (state_nxt == S_RST_P);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         frame_cnt <= '0;
         jump_fail <= 1'b0;
         end_en    <= 1'b0;
         freeze    <= 1'b0;
         restart   <= 1'b0;
      end else begin
         state     <= state_nxt;
         frame_cnt <= frame_cnt_nxt;
         jump_fail <= jump_fail_nxt;
         end_en    <= end_en_nxt;
         freeze    <= end_en_nxt;
         restart   <= restart_nxt;
      end
   end

endmodule

// File: tb/tb_game_end_ctrl.sv
// Bench for game_end_ctrl: directed scenarios followed by random traffic, all checked against a behavioural model.
module tb_game_end_ctrl;

   localparam int MIN_T = 30;
   localparam int HOLD_T = 300;
   localparam int CMAX = 1023;

   logic clk = 1'b0;
   logic rst, game_running, time_up, jump_fail_evt, frame_tick, btn_press;
   logic end_en, jump_fail, freeze, restart;

   int errors = 0;
   int checks = 0;

   // Behavioural model: is the end screen showing, has the lockout elapsed, is a restart being signalled.
   bit m_armed, m_screen, m_open, m_pulse, m_cause;
   int m_ticks;

   always #5 clk = ~clk;

   game_end_ctrl #(
      .MIN_HOLD_FRAMES(MIN_T),
      .HOLD_FRAMES(HOLD_T),
      .FRAME_CNT_W(10)
   ) dut (
      .clk(clk),
      .rst(rst),
      .game_running(game_running),
      .time_up(time_up),
      .jump_fail_evt(jump_fail_evt),
      .frame_tick(frame_tick),
      .btn_press(btn_press),
      .end_en(end_en),
      .jump_fail(jump_fail),
      .freeze(freeze),
      .restart(restart)
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic model_step(input bit r, input bit gr, input bit tu, input bit jf,
                             input bit tk, input bit bt);
      bit auto_hit;
`ifdef GAME_END_AUTO_RESTART_EN
      auto_hit = (m_ticks == HOLD_T);
`else
      auto_hit = 1'b0;
`endif
      if (r) begin
         m_armed = 0; m_screen = 0; m_open = 0; m_pulse = 0; m_cause = 0; m_ticks = 0;
      end else if (m_pulse) begin
         m_pulse = 0; m_screen = 0; m_open = 0;
      end else if (m_screen) begin
         if (m_open && (bt || auto_hit)) begin
            m_pulse = 1;
         end else begin
            if (!m_open && m_ticks == MIN_T) m_open = 1;
            if (tk && m_ticks < CMAX) m_ticks++;
         end
      end else if (m_armed) begin
         if (jf || tu) begin
            m_screen = 1; m_cause = jf; m_ticks = 0; m_open = 0; m_armed = 0;
         end else if (!gr) begin
            m_armed = 0;
         end
      end else if (gr) begin
         m_armed = 1;
      end
   endtask

   task automatic cycle(input bit r, input bit gr, input bit tu, input bit jf,
                        input bit tk, input bit bt, input string tag);
      rst = r; game_running = gr; time_up = tu; jump_fail_evt = jf;
      frame_tick = tk; btn_press = bt;
      @(posedge clk);
      model_step(r, gr, tu, jf, tk, bt);
      #1;
      chk($sformatf("%s.end_en", tag), end_en, m_screen);
      chk($sformatf("%s.freeze", tag), freeze, m_screen);
      chk($sformatf("%s.restart", tag), restart, m_pulse);
      chk($sformatf("%s.jump_fail", tag), jump_fail, m_cause);
   endtask

   initial begin
      int restart_seen;
      m_armed = 0; m_screen = 0; m_open = 0; m_pulse = 0; m_cause = 0; m_ticks = 0;

      // Reset values
      cycle(1, 0, 0, 0, 0, 0, "rst");
      chk("rst_end_en_zero", end_en, 1'b0);
      chk("rst_restart_zero", restart, 1'b0);

      // Time-up ends the game with cause = time
      cycle(0, 1, 0, 0, 0, 0, "t1_arm");
      cycle(0, 1, 1, 0, 0, 0, "t1_tu");
      chk("t1_end_en_on", end_en, 1'b1);
      chk("t1_freeze_on", freeze, 1'b1);
      chk("t1_cause_time", jump_fail, 1'b0);

      // Button during lockout is ignored, accepted after 31 ticks
      repeat (10) cycle(0, 1, 0, 0, 1, 0, "t3_tick");
      cycle(0, 1, 0, 0, 0, 1, "t3_early_btn");
      chk("t3_early_no_restart", restart, 1'b0);
      chk("t3_early_still_on", end_en, 1'b1);
      repeat (21) cycle(0, 1, 0, 0, 1, 0, "t3_tick2");
      cycle(0, 1, 0, 0, 0, 0, "t3_idle");
      cycle(0, 1, 0, 0, 0, 1, "t3_btn");
      chk("t3_restart_hi", restart, 1'b1);
      cycle(0, 1, 0, 0, 0, 0, "t3_after");
      chk("t3_restart_lo", restart, 1'b0);
      chk("t3_end_en_off", end_en, 1'b0);
      chk("t3_freeze_off", freeze, 1'b0);

      // Simultaneous events: jump failure wins
      cycle(0, 1, 0, 0, 0, 0, "t2_arm");
      cycle(0, 1, 1, 1, 0, 0, "t2_both");
      chk("t2_cause_jump", jump_fail, 1'b1);
      chk("t2_end_en_on", end_en, 1'b1);

      // Events during WAIT are dropped
      repeat (31) cycle(0, 1, 0, 0, 1, 0, "t4_tick");
      repeat (3) begin
         cycle(0, 1, 1, 0, 0, 0, "t4_tu");
         cycle(0, 1, 0, 0, 0, 0, "t4_gap");
      end
      chk("t4_cause_kept", jump_fail, 1'b1);
      chk("t4_still_on", end_en, 1'b1);

      // Reset while in WAIT
      cycle(1, 1, 0, 0, 0, 0, "t5_rst");
      chk("t5_end_en_off", end_en, 1'b0);
      chk("t5_cause_clr", jump_fail, 1'b0);

      // Long stay on the end screen with no button
      cycle(0, 1, 0, 0, 0, 0, "t6_arm");
      cycle(0, 1, 1, 0, 0, 0, "t6_tu");
      restart_seen = 0;
      for (int i = 0; i < 1000; i++) begin
         cycle(0, 1, 0, 0, 1, 0, "t6_tick");
         if (restart === 1'b1) restart_seen++;
      end
`ifdef GAME_END_AUTO_RESTART_EN
      chk("t6_auto_restart_once", restart_seen == 1, 1'b1);
`else
      chk("t6_no_restart", restart_seen == 0, 1'b1);
      chk("t6_end_en_held", end_en, 1'b1);
`endif

      // Random traffic
      cycle(1, 0, 0, 0, 0, 0, "rnd_rst");
      for (int i = 0; i < 4000; i++) begin
         cycle($urandom_range(0, 299) == 0, $urandom_range(0, 15) != 0,
               $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0,
               $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, "rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
